mem_port_arbiter: RTL and testbench

Shares the single unified memory port between instruction fetch (IF) and the data load/store path (DM: STR/LDRB) in the multi-cycle ARM core. Accepts level-held requests from both sides, serialises them onto one req/ack memory interface, and returns read data with a one-cycle ready pulse. Data accesses have priority so that an in-flight load/store is never blocked behind fetch. Sits between the fetch stage, the control-unit-driven memory stage, and the memory model.

---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/mem_arb_fair_counter.sv | 36 +++
 rtl/mem_port_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory-port arbiter.
// States, grant-source encoding and default widths.
package mem_arb_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;
   localparam int BURST_DEF  = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_IF = 2'd1,
      BUSY_DM = 2'd2,
      RESP    = 2'd3
   } arb_state_e;

   typedef enum logic {
      GNT_IF = 1'b0,
      GNT_DM = 1'b1
   } gnt_src_e;

   function automatic logic is_busy(input arb_state_e s);
      return (s == BUSY_IF) || (s == BUSY_DM);
   endfunction

endpackage

// File: rtl/mem_arb_fair_counter.sv
// Saturating count of data grants made while fetch waits.
// Forces a fetch grant once the burst limit is reached.
module mem_arb_fair_counter #(
   parameter int MAX_DATA_BURST = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic idle,
   input  logic if_req,
   input  logic dm_req,
   input  logic gnt_dm,
   input  logic gnt_if,
   output logic force_if
);

   localparam int CW = $clog2(MAX_DATA_BURST + 1);
   localparam logic [CW-1:0] CMAX = CW'(MAX_DATA_BURST);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (gnt_if) begin
         cnt <= '0;
      end else if (gnt_dm && if_req) begin
         if (cnt != CMAX)
            cnt <= cnt + CW'(1);
      end else if (idle && !if_req) begin
         cnt <= '0;
      end
   end

   assign force_if = (cnt == CMAX) && if_req && dm_req;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one req/ack memory port between fetch and data accesses.
// Data has priority; define ARB_FAIRNESS_EN to bound fetch starvation.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W         = ADDR_W_DEF,
   parameter int DATA_W         = DATA_W_DEF,
   parameter int MAX_DATA_BURST = BURST_DEF
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ready,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              dm_req,
   input  logic              dm_write,
   input  logic              dm_byte,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_ready,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              mem_req,
   output logic              mem_write,
   output logic              mem_byte,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack
);

   arb_state_e state;
   arb_state_e state_nxt;
   gnt_src_e   gnt_q;

   logic idle;
   logic force_if;
   logic grant_dm;
   logic grant_if;

   assign idle = (state == IDLE);

`ifdef ARB_FAIRNESS_EN
   mem_arb_fair_counter #(
      .MAX_DATA_BURST(MAX_DATA_BURST)
   ) u_fair (
      .clk      (clk),
      .reset_n  (reset_n),
      .idle     (idle),
      .if_req   (if_req),
      .dm_req   (dm_req),
      .gnt_dm   (grant_dm),
      .gnt_if   (grant_if),
      .force_if (force_if)
   );
`else
   // Strict data priority: the burst limit can never force a fetch.
   assign force_if = (MAX_DATA_BURST < 0);
`endif

   assign grant_dm = idle && dm_req && !force_if;
   assign grant_if = idle && if_req && (!dm_req || force_if);

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            unique case (1'b1)
               grant_dm: state_nxt = BUSY_DM;
               grant_if: state_nxt = BUSY_IF;
               default:  state_nxt = IDLE;
            endcase
         end
         BUSY_IF,
         BUSY_DM: begin
            if (mem_ack)
               state_nxt = RESP;
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         gnt_q <= GNT_IF;
      end else begin
         state <= state_nxt;
         if (grant_dm)
            gnt_q <= GNT_DM;
         else if (grant_if)
            gnt_q <= GNT_IF;
      end
   end

   // Fetches never write, so their write-side fields are zeroed.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_write <= 1'b0;
         mem_byte  <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else if (grant_dm) begin
         mem_write <= dm_write;
         mem_byte  <= dm_byte;
         mem_addr  <= dm_addr;
         mem_wdata <= dm_wdata;
      end else if (grant_if) begin
         mem_write <= 1'b0;
         mem_byte  <= 1'b0;
         mem_addr  <= if_addr;
         mem_wdata <= '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         if_rdata <= '0;
         dm_rdata <= '0;
      end else if (mem_ack) begin
         if (state == BUSY_IF)
            if_rdata <= mem_rdata;
         if (state == BUSY_DM && !mem_write)
            dm_rdata <= mem_rdata;
      end
   end

   assign mem_req  = is_busy(state);
   assign if_ready = (state == RESP) && (gnt_q == GNT_IF);
   assign dm_ready = (state == RESP) && (gnt_q == GNT_DM);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed cases then a randomized
// scoreboard run with a memory model and a reference arbiter.
module tb_mem_port_arbiter;

   localparam int MAXB = 4;
`ifdef ARB_FAIRNESS_EN
   localparam bit FAIR = 1'b1;
`else
   localparam bit FAIR = 1'b0;
`endif

   logic        clk;
   logic        reset_n;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_ready;
   logic [31:0] if_rdata;
   logic        dm_req;
   logic        dm_write;
   logic        dm_byte;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic        dm_ready;
   logic [31:0] dm_rdata;
   logic        mem_req;
   logic        mem_write;
   logic        mem_byte;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   mem_port_arbiter #(
      .ADDR_W(32), .DATA_W(32), .MAX_DATA_BURST(MAXB)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .if_req(if_req), .if_addr(if_addr),
      .if_ready(if_ready), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_write(dm_write),
      .dm_byte(dm_byte), .dm_addr(dm_addr),
      .dm_wdata(dm_wdata), .dm_ready(dm_ready),
      .dm_rdata(dm_rdata),
      .mem_req(mem_req), .mem_write(mem_write),
      .mem_byte(mem_byte), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_ack(mem_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h @%0t",
                  name, act, exp, $time);
      end
   endtask

   typedef struct packed {
      logic        wr;
      logic        bs;
      logic [31:0] addr;
      logic [31:0] wd;
   } gnt_t;

   gnt_t        gnt_q[$];
   gnt_t        g;
   logic [31:0] if_exp_q[$];
   logic [31:0] dm_exp_q[$];
   logic [31:0] mem_arr[logic [31:0]];
   logic [31:0] ref_arr[logic [31:0]];
   logic [31:0] dm_last;
   logic        prev_mem_req = 1'b0;
   bit          sb_en = 1'b0;
   bit          mem_en = 1'b0;
   int          fair_cnt = 0;

   function automatic logic [31:0] init_word(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
   endfunction

   function automatic logic [31:0] rd_word(input bit use_ref,
                                           input logic [31:0] a);
      logic [31:0] w;
      w = {a[31:2], 2'b00};
      if (use_ref)
         return ref_arr.exists(w) ? ref_arr[w] : init_word(w);
      return mem_arr.exists(w) ? mem_arr[w] : init_word(w);
   endfunction

   // Memory returns whole words, or a zero-extended byte lane.
   function automatic logic [31:0] rd_data(input bit use_ref,
                                           input logic [31:0] a,
                                           input logic bs);
      logic [31:0] w;
      w = rd_word(use_ref, a);
      if (bs)
         return {24'b0, w[8*a[1:0] +: 8]};
      return w;
   endfunction

   // Memory model: random ack latency plus stray acks when idle.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (!mem_en) continue;
         mem_ack = 1'b0;
         if (mem_req) begin
            repeat ($urandom_range(0, 3)) begin
               @(posedge clk);
               #1;
            end
            mem_ack = 1'b1;
            if (mem_write) begin
               mem_arr[{mem_addr[31:2], 2'b00}] = mem_wdata;
               mem_rdata = $urandom;
            end else begin
               mem_rdata = rd_data(1'b0, mem_addr, mem_byte);
            end
         end else if ($urandom_range(0, 7) == 0) begin
            mem_ack   = 1'b1;
            mem_rdata = $urandom;
         end
      end
   end

   // Monitor and reference arbiter, sampled mid-cycle.
   always @(negedge clk) begin
      if (sb_en) begin
         if (mem_req && !prev_mem_req) begin
            chk("grant_expected", 32'(gnt_q.size() != 0), 1);
            if (gnt_q.size() != 0) begin
               g = gnt_q.pop_front();
               chk("gnt_addr", mem_addr, g.addr);
               chk("gnt_write", mem_write, g.wr);
               chk("gnt_byte", mem_byte, g.bs);
               chk("gnt_wdata", mem_wdata, g.wd);
            end
         end
         prev_mem_req = mem_req;
         if (if_ready || dm_ready)
            chk("ready_overlap", 32'(if_ready && dm_ready), 0);
         if (if_ready) begin
            chk("if_resp_expected", 32'(if_exp_q.size() != 0), 1);
            if (if_exp_q.size() != 0)
               chk("if_rdata", if_rdata, if_exp_q.pop_front());
         end
         if (dm_ready) begin
            chk("dm_resp_expected", 32'(dm_exp_q.size() != 0), 1);
            if (dm_exp_q.size() != 0)
               chk("dm_rdata", dm_rdata, dm_exp_q.pop_front());
         end
         if (!mem_req && !if_ready && !dm_ready) begin
            if (dm_req && !(FAIR && fair_cnt == MAXB && if_req)) begin
               gnt_q.push_back({dm_write, dm_byte, dm_addr, dm_wdata});
               if (if_req && fair_cnt < MAXB)
                  fair_cnt++;
            end else if (if_req) begin
               gnt_q.push_back({1'b0, 1'b0, if_addr, 32'h0});
               fair_cnt = 0;
            end else begin
               fair_cnt = 0;
            end
         end
      end
   end

   task automatic if_driver(input int n);
      logic [31:0] a;
      bit ok;
      for (int i = 0; i < n; i++) begin
         if_req = 1'b0;
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
         end
         a = 32'h1000 + 4 * $urandom_range(0, 63);
         if_addr = a;
         if_req  = 1'b1;
         if_exp_q.push_back(rd_data(1'b1, a, 1'b0));
         ok = 1'b0;
         for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (if_ready) begin
               ok = 1'b1;
               break;
            end
         end
         chk("if_ready_in_time", 32'(ok), 1);
         @(posedge clk);
         #1;
      end
      if_req = 1'b0;
   endtask

   task automatic dm_driver(input int n);
      logic [31:0] a;
      logic [31:0] d;
      bit ok;
      for (int i = 0; i < n; i++) begin
         dm_req = 1'b0;
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
         end
         a = 32'h40 + $urandom_range(0, 63);
         dm_write = $urandom_range(0, 1) == 1;
         dm_byte  = !dm_write && ($urandom_range(0, 1) == 1);
         if (!dm_byte)
            a[1:0] = 2'b00;
         d = $urandom;
         dm_addr  = a;
         dm_wdata = d;
         dm_req   = 1'b1;
         if (dm_write) begin
            ref_arr[a] = d;
         end else begin
            dm_last = rd_data(1'b1, a, dm_byte);
         end
         dm_exp_q.push_back(dm_last);
         ok = 1'b0;
         for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (dm_ready) begin
               ok = 1'b1;
               break;
            end
         end
         chk("dm_ready_in_time", 32'(ok), 1);
         @(posedge clk);
         #1;
      end
      dm_req = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0;
      if_req = 1'b0; if_addr = '0;
      dm_req = 1'b0; dm_write = 1'b0; dm_byte = 1'b0;
      dm_addr = '0; dm_wdata = '0;
      mem_ack = 1'b0; mem_rdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_readies", {if_ready, dm_ready}, 0);
      chk("rst_if_rdata", if_rdata, 0);
      @(posedge clk); #1;
      reset_n = 1'b1;

      // Fetch at 0x100 acked in the first busy cycle.
      @(posedge clk); #1;
      if_req = 1'b1; if_addr = 32'h100;
      @(posedge clk); #1;
      mem_ack = 1'b1; mem_rdata = 32'hE3A01005;
      @(negedge clk);
      chk("f_mem_req_c1", mem_req, 1);
      chk("f_mem_addr", mem_addr, 32'h100);
      chk("f_mem_write", mem_write, 0);
      chk("f_if_ready_c1", if_ready, 0);
      @(posedge clk); #1;
      mem_ack = 1'b0; mem_rdata = '0; if_req = 1'b0;
      @(negedge clk);
      chk("f_if_ready_c2", if_ready, 1);
      chk("f_if_rdata", if_rdata, 32'hE3A01005);
      chk("f_mem_req_c2", mem_req, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("f_if_ready_pulse", if_ready, 0);

      // Store with ack in the third busy cycle.
      @(posedge clk); #1;
      dm_req = 1'b1; dm_write = 1'b1;
      dm_addr = 32'h40; dm_wdata = 32'hDEADBEEF;
      for (int c = 1; c <= 3; c++) begin
         @(posedge clk); #1;
         if (c == 3) begin
            mem_ack = 1'b1; mem_rdata = 32'h12345678;
         end
         @(negedge clk);
         chk("s_mem_req", mem_req, 1);
         chk("s_dm_ready_early", dm_ready, 0);
      end
      chk("s_mem_write", mem_write, 1);
      chk("s_mem_wdata", mem_wdata, 32'hDEADBEEF);
      @(posedge clk); #1;
      mem_ack = 1'b0; dm_req = 1'b0; dm_write = 1'b0;
      @(negedge clk);
      chk("s_dm_ready", dm_ready, 1);
      chk("s_dm_rdata_kept", dm_rdata, 0);
      chk("s_mem_req_drop", mem_req, 0);

      // LDRB and fetch raised together: data first.
      @(posedge clk); #1;
      dm_req = 1'b1; dm_byte = 1'b1; dm_addr = 32'h23;
      if_req = 1'b1; if_addr = 32'h104;
      @(posedge clk); #1;
      mem_ack = 1'b1; mem_rdata = 32'h000000AB;
      @(negedge clk);
      chk("c_dm_first_byte", mem_byte, 1);
      chk("c_dm_first_addr", mem_addr, 32'h23);
      @(posedge clk); #1;
      mem_ack = 1'b0; dm_req = 1'b0; dm_byte = 1'b0;
      @(negedge clk);
      chk("c_readies_1", {if_ready, dm_ready}, 2'b01);
      chk("c_dm_rdata", dm_rdata, 32'hAB);
      @(posedge clk); #1;
      @(posedge clk); #1;
      mem_ack = 1'b1; mem_rdata = 32'hE1A00000;
      @(negedge clk);
      chk("c_if_addr", mem_addr, 32'h104);
      chk("c_if_byte", mem_byte, 0);
      @(posedge clk); #1;
      mem_ack = 1'b0; if_req = 1'b0;
      @(negedge clk);
      chk("c_readies_2", {if_ready, dm_ready}, 2'b10);
      chk("c_if_rdata", if_rdata, 32'hE1A00000);

      // Reset mid-load, then a late ack.
      @(posedge clk); #1;
      dm_req = 1'b1; dm_addr = 32'h44;
      @(posedge clk); #1;
      @(negedge clk);
      chk("r_mem_req_busy", mem_req, 1);
      #2 reset_n = 1'b0;
      #1;
      chk("r_mem_req", mem_req, 0);
      chk("r_mem_addr", mem_addr, 0);
      chk("r_dm_rdata", dm_rdata, 0);
      @(posedge clk); #1;
      reset_n = 1'b1; dm_req = 1'b0;
      mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("r_no_ready", {if_ready, dm_ready, mem_req}, 0);
      end
      chk("r_stray_dm_rdata", dm_rdata, 0);
      chk("r_stray_if_rdata", if_rdata, 0);

      // Randomized traffic against the scoreboard.
      @(posedge clk); #1;
      dm_last = '0;
      fair_cnt = 0;
      sb_en = 1'b1;
      mem_en = 1'b1;
      fork
         if_driver(60);
         dm_driver(60);
      join
      repeat (10) @(posedge clk);
      chk("if_q_drained", if_exp_q.size(), 0);
      chk("dm_q_drained", dm_exp_q.size(), 0);
      chk("gnt_q_drained", gnt_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
